// File: rtl/stft_pkg.sv
// Shared types and helpers for the STFT stages that follow the FFT.
package stft_pkg;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        IN_FRAME  = 1'b1
    } align_state_t;

    // Number of non-redundant bins of a real-input FFT frame.
    function automatic int nbins(input int fft_size);
        return fft_size / 2 + 1;
    endfunction

    // Truncating right shift, then clamp to the largest unsigned pw-bit value.
    function automatic logic [63:0] sat_shift(input logic [63:0] value,
                                              input int          shift,
                                              input int          pw);
        logic [63:0] v;
        logic [63:0] max_v;
        v     = value >> shift;
        max_v = (pw >= 64) ? '1 : ((64'd1 << pw) - 64'd1);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/stft_fifo.sv
// First-word-fall-through synchronous FIFO with a registered output word.
// Capacity counts the output register, so at most DEPTH words are held.
module stft_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic [CW-1:0]    total;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             pop;
    logic             push;
    logic             load;

    assign total = mem_cnt + CW'(out_vld);
    assign full  = (total == CW'(DEPTH));
    assign pop   = out_vld & rd_en;
    // A pop frees a slot in the same cycle, so a full FIFO still takes the write.
    assign push  = wr_en & (~full | pop);
    assign load  = (mem_cnt != '0) & (~out_vld | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr   <= rd_ptr + AW'(1);
                out_data <= mem[rd_ptr];
                out_vld  <= 1'b1;
            end else if (pop) begin
                out_vld <= 1'b0;
            end
            mem_cnt <= mem_cnt + CW'(push) - CW'(load);
        end
    end

    assign rd_data = out_data;
    assign empty   = ~out_vld;

endmodule

// File: rtl/fft_power_frame.sv
// Per-bin power of the FFT output stream, restricted to bins 0..FFT_SIZE/2,
// framed by the FFT sync and buffered for a back-pressuring consumer.
module fft_power_frame
    import stft_pkg::*;
#(
    parameter int IW         = 18,
    parameter int PW         = 24,
    parameter int SHIFT      = 12,
    parameter int FFT_SIZE   = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_ce,
    input  logic [2*IW-1:0]             i_fft_result,
    input  logic                        i_fft_sync,
    input  logic                        i_clear_flags,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [PW-1:0]               o_power,
    output logic [$clog2(FFT_SIZE)-1:0] o_bin,
    output logic                        o_first,
    output logic                        o_last,
    output logic                        o_overflow,
    output logic                        o_sync_err
);

    localparam int BW   = $clog2(FFT_SIZE);
    localparam int HALF = nbins(FFT_SIZE) - 1;
    localparam int SW   = 2 * IW + 1;
    localparam int FW   = PW + BW + 2;
    localparam logic [BW-1:0] LAST_BIN = BW'(FFT_SIZE - 1);
    localparam logic [BW-1:0] HALF_BIN = BW'(HALF);

    function automatic logic [2*IW-1:0] square(input logic signed [IW-1:0] x);
        logic signed [2*IW-1:0] xe;
        xe = {{IW{x[IW-1]}}, x};
        return $unsigned(xe * xe);
    endfunction

    align_state_t  state;
    align_state_t  state_next;
    logic [BW-1:0] cnt;
    logic [BW-1:0] cnt_next;
    logic [BW-1:0] cnt_inc;
    logic          fwd;
    logic          serr_set;

    assign cnt_inc = cnt + BW'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_ce) begin
            if (i_fft_sync) begin
                state_next = IN_FRAME;
            end else if (state == IN_FRAME && cnt == LAST_BIN) begin
                state_next = WAIT_SYNC;
            end
        end
    end

    // A sync always restarts the frame; a missing sync after the last bin drops alignment.
    always_comb begin
        cnt_next = cnt;
        fwd      = 1'b0;
        serr_set = 1'b0;
        if (i_ce) begin
            if (i_fft_sync) begin
                cnt_next = '0;
                fwd      = 1'b1;
                serr_set = (state == IN_FRAME) && (cnt != LAST_BIN);
            end else if (state == IN_FRAME) begin
                if (cnt == LAST_BIN) begin
                    serr_set = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                    fwd      = (cnt_inc <= HALF_BIN);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    logic signed [IW-1:0] re_in;
    logic signed [IW-1:0] im_in;
    assign re_in = i_fft_result[2*IW-1:IW];
    assign im_in = i_fft_result[IW-1:0];

    logic            vld_p0;
    logic            vld_p1;
    logic            vld_p2;
    logic [2*IW-1:0] re_sq_p0;
    logic [2*IW-1:0] im_sq_p0;
    logic [BW-1:0]   bin_p0;
    logic [SW-1:0]   sum_p1;
    logic [BW-1:0]   bin_p1;
    logic [PW-1:0]   pwr_p2;
    logic [BW-1:0]   bin_p2;
    logic [PW-1:0]   pwr_next;

    assign pwr_next = PW'(sat_shift(64'(sum_p1), SHIFT, PW));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= fwd;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge i_clk) begin
        // p0: squares
        re_sq_p0 <= square(re_in);
        im_sq_p0 <= square(im_in);
        bin_p0   <= cnt_next;
        // p1: sum
        sum_p1   <= {1'b0, re_sq_p0} + {1'b0, im_sq_p0};
        bin_p1   <= bin_p0;
        // p2: shift and saturate
        pwr_p2   <= pwr_next;
        bin_p2   <= bin_p1;
    end

    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_wr_data;
    logic [FW-1:0] fifo_rd_data;
    logic          drop;

    assign fifo_wr_data = {(bin_p2 == HALF_BIN), (bin_p2 == '0), bin_p2, pwr_p2};
    assign drop         = vld_p2 & fifo_full & ~(~fifo_empty & i_ready);

    stft_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .wr_en   (vld_p2),
        .wr_data (fifo_wr_data),
        .full    (fifo_full),
        .rd_en   (i_ready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign o_valid = ~fifo_empty;
    assign {o_last, o_first, o_bin, o_power} = fifo_rd_data;

    // Setting events take priority over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow <= 1'b0;
            o_sync_err <= 1'b0;
        end else begin
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clear_flags) begin
                o_overflow <= 1'b0;
            end
            if (serr_set) begin
                o_sync_err <= 1'b1;
            end else if (i_clear_flags) begin
                o_sync_err <= 1'b0;
            end
        end
    end

endmodule
